fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Control FSM that drives the fetch stage's PC-source controls (pc_place, pc_select) and the fetch/decode buffer enable, once per clock.
- Handles boot from the reset vector, sequential advance by instruction size, stalls, call/return redirects and interrupt entry through the IVT.
- Sits between the hazard/decode/execute control signals and the fetch stage; the fetch stage's PC mux remains purely combinational.

Parameters:
BOOT_CYCLES, 2, cycles held in BOOT (reset vector driven) after reset release; legal range 1..15.
INT_SAVE_CYCLES, 2, cycles spent in INT_SAVE letting the pipeline push PC/flags; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  hazard unit freezes fetch this cycle
inst_is_32  in  1  instruction currently fetched is 32-bit (advance +4, else +2)
call_taken  in  1  execute resolved a CALL/jump; redirect to call target
ret_taken  in  1  execute resolved a RET/RTI; redirect to popped address
int_req  in  1  external interrupt request, level, sampled each cycle
int_index_in  in  3  interrupt vector index accompanying int_req
pc_place  out  4  PC source code to fetch
pc_select  out  2  increment size code to fetch
index  out  3  latched vector index to fetch (IVT offset)
enable_buf  out  1  fetch/decode buffer write enable
flush  out  1  one-cycle pulse: squash younger instructions in buffers
save_pc  out  1  high during INT_SAVE: execute pushes return PC
int_ack  out  1  one-cycle pulse when the IVT jump is issued

Behaviour:
- Encodings: pc_place SEQ=0, IVT=5, RET=6, CALL=7, RESET=8. pc_select HOLD=00, +2=01, +4=10.
- States: BOOT, RUN, INT_SAVE, INT_JUMP. Two state bits plus a 4-bit cycle counter.
- Reset asserted (reset=0) asynchronously forces:
  - state=BOOT, counter=0, pending interrupt cleared, index=0.
  - Outputs during reset: pc_place=8, pc_select=00, enable_buf=0, flush=0, save_pc=0, int_ack=0.
- Outputs are combinational from the registered state, counter, pending flag and same-cycle inputs. State and counter update on the rising clk edge.
- BOOT:
  - Drives pc_place=8, pc_select=00, enable_buf=0.
  - Counter increments each cycle; at counter==BOOT_CYCLES-1, moves to RUN and clears the counter.
  - All other inputs are ignored; an int_req arriving in BOOT is latched as pending.
- RUN, evaluated in priority order; the first match wins in each cycle:
  - ret_taken → pc_place=6, flush=1, enable_buf=1.
  - else call_taken → pc_place=7, flush=1, enable_buf=1.
  - else pending or int_req → go to INT_SAVE; this cycle pc_place=0, pc_select=00, enable_buf=0, flush=1; latch index from int_index_in if int_req is high, otherwise keep the stored index.
  - else stall → pc_place=0, pc_select=00, enable_buf=0.
  - else → pc_place=0, pc_select = inst_is_32 ? 10 : 01, enable_buf=1.
- Simultaneous events:
  - ret_taken and call_taken together: ret wins.
  - A redirect plus int_req in the same cycle: the redirect wins and the interrupt becomes pending, serviced in the next RUN cycle with no redirect.
  - stall never blocks a redirect or interrupt entry.
- INT_SAVE:
  - save_pc=1, pc_place=0, pc_select=00, enable_buf=0.
  - Counter counts to INT_SAVE_CYCLES-1, then moves to INT_JUMP.
  - stall extends INT_SAVE: the counter holds while stall=1.
  - New int_req is ignored except to set pending; index is not overwritten.
- INT_JUMP (exactly one cycle):
  - pc_place=5, index=latched value, enable_buf=1, int_ack=1, flush=0.
  - Pending is cleared, then the FSM returns to RUN.
  - If stall=1 in this cycle, the FSM remains in INT_JUMP with int_ack=0 and enable_buf=0; int_ack pulses only on the cycle the jump is accepted.
- Pending flag:
  - Set by int_req in any state other than in the RUN entry cycle itself.
  - Cleared only in an accepted INT_JUMP.
  - One interrupt is serviced per INT_JUMP; a level held high re-enters after the jump.
- Reset asserted mid-INT_SAVE or mid-INT_JUMP aborts immediately to BOOT; no int_ack is produced.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - pc_place codes PLACE_SEQ/IVT/RET/CALL/RESET;
  - pc_select codes SEL_HOLD/SEL_2/SEL_4;
  - the state encoding.
- Natural sub-module: fetch_int_latch. It holds the pending flag and the 3-bit index, with set/clear/load controls and the asynchronous active-low reset.

Test Plan:
1. Reset released with BOOT_CYCLES=2 → pc_place=8 for 2 cycles, enable_buf=0; cycle 3 pc_place=0, pc_select=01 (inst_is_32=0).
2. RUN with inst_is_32 alternating 1,0,1 and stall=0 → pc_select 10,01,10 with enable_buf=1; then stall=1 for 2 cycles → pc_select=00, enable_buf=0.
3. ret_taken=1 and call_taken=1 in the same cycle → pc_place=6, flush=1 for exactly one cycle; next cycle pc_place=0.
4. int_req=1, int_index_in=3 in RUN, INT_SAVE_CYCLES=2 → flush pulse, then save_pc=1 for 2 cycles, then pc_place=5, index=3, int_ack=1 for one cycle, then RUN.
5. call_taken=1 with int_req=1, int_index_in=5 → pc_place=7 first; next cycle INT_SAVE entry; later INT_JUMP with index=5.
6. reset driven low during the second INT_SAVE cycle → outputs immediately show reset values; int_ack never asserts; BOOT sequence restarts after release.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer slice.
// Contents:
//   - pc_place source codes consumed by the fetch-stage PC mux.
//   - pc_select increment codes.
//   - FSM state encoding.
//   - Interrupt index and cycle-counter widths.
package fetch_ctrl_pkg;

  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  localparam logic [3:0] PLACE_SEQ   = 4'd0;
  localparam logic [3:0] PLACE_IVT   = 4'd5;
  localparam logic [3:0] PLACE_RET   = 4'd6;
  localparam logic [3:0] PLACE_CALL  = 4'd7;
  localparam logic [3:0] PLACE_RESET = 4'd8;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_2    = 2'b01;
  localparam logic [1:0] SEL_4    = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_INT_SAVE = 2'd2,
    ST_INT_JUMP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the surrounding pipeline.
// Modports:
//   - master: the sequencer. It takes hazard/execute/interrupt controls
//     (stall, inst_is_32, call_taken, ret_taken, int_req, int_index_in) and
//     drives the fetch controls (pc_place, pc_select, index, enable_buf,
//     flush, save_pc, int_ack).
//   - slave: the pipeline side, with the opposite directions.
interface fetch_sequencer_if;
  import fetch_ctrl_pkg::*;

  logic             stall;
  logic             inst_is_32;
  logic             call_taken;
  logic             ret_taken;
  logic             int_req;
  logic [IDX_W-1:0] int_index_in;
  logic [3:0]       pc_place;
  logic [1:0]       pc_select;
  logic [IDX_W-1:0] index;
  logic             enable_buf;
  logic             flush;
  logic             save_pc;
  logic             int_ack;

  modport master (
    input  stall, inst_is_32, call_taken, ret_taken, int_req, int_index_in,
    output pc_place, pc_select, index, enable_buf, flush, save_pc, int_ack
  );

  modport slave (
    output stall, inst_is_32, call_taken, ret_taken, int_req, int_index_in,
    input  pc_place, pc_select, index, enable_buf, flush, save_pc, int_ack
  );
endinterface

// File: rtl/fetch_int_latch.sv
// Pending-interrupt flag and latched vector index.
// Ports:
//   - clk, reset: clock and asynchronous active-low reset.
//   - set_pend / clr_pend: set or clear the pending flag. Clear has priority,
//     so an accepted jump always retires exactly one interrupt.
//   - load_idx, idx_in: capture a new vector index.
//   - pending, index: registered flag and index.
module fetch_int_latch
  import fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_pend,
  input  logic             clr_pend,
  input  logic             load_idx,
  input  logic [IDX_W-1:0] idx_in,
  output logic             pending,
  output logic [IDX_W-1:0] index
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      index   <= '0;
    end else begin
      if (clr_pend)      pending <= 1'b0;
      else if (set_pend) pending <= 1'b1;
      if (load_idx)      index   <= idx_in;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM.
// Each cycle it picks the PC source (pc_place), the increment size
// (pc_select) and the fetch/decode buffer enable. It covers:
//   - boot from the reset vector;
//   - sequential advance by instruction size;
//   - stalls;
//   - call/return redirects;
//   - interrupt entry through the IVT.
// Ports:
//   - clk, reset: clock and asynchronous active-low reset.
//   - bus: fetch_sequencer_if master modport carrying all control signals.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES     = 2,
  parameter int INT_SAVE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAVE_LAST = CNT_W'(INT_SAVE_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_pend, clr_pend, load_idx;
  logic             pending;
  logic [IDX_W-1:0] index;
  logic [3:0]       place;
  logic [1:0]       sel;
  logic             enable_buf, flush, save_pc, int_ack;

  fetch_int_latch u_int_latch (
    .clk      (clk),
    .reset    (reset),
    .set_pend (set_pend),
    .clr_pend (clr_pend),
    .load_idx (load_idx),
    .idx_in   (bus.int_index_in),
    .pending  (pending),
    .index    (index)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    place      = PLACE_SEQ;
    sel        = SEL_HOLD;
    enable_buf = 1'b0;
    flush      = 1'b0;
    save_pc    = 1'b0;
    int_ack    = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    load_idx   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        place    = PLACE_RESET;
        set_pend = bus.int_req;
        load_idx = bus.int_req;
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.ret_taken || bus.call_taken) begin
          // A redirect wins over interrupt entry; a coincident request is
          // parked as pending and taken on the next redirect-free cycle.
          place      = bus.ret_taken ? PLACE_RET : PLACE_CALL;
          flush      = 1'b1;
          enable_buf = 1'b1;
          set_pend   = bus.int_req;
          load_idx   = bus.int_req;
        end else if (pending || bus.int_req) begin
          state_d  = ST_INT_SAVE;
          cnt_d    = '0;
          flush    = 1'b1;
          load_idx = bus.int_req;
        end else if (!bus.stall) begin
          sel        = bus.inst_is_32 ? SEL_4 : SEL_2;
          enable_buf = 1'b1;
        end
      end

      ST_INT_SAVE: begin
        save_pc  = 1'b1;
        set_pend = bus.int_req;
        // The counter freezes under stall so the push always gets its full
        // number of productive cycles.
        if (!bus.stall) begin
          if (cnt_q == SAVE_LAST) begin
            state_d = ST_INT_JUMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_INT_JUMP: begin
        place = PLACE_IVT;
        if (bus.stall) begin
          set_pend = bus.int_req;
        end else begin
          enable_buf = 1'b1;
          int_ack    = 1'b1;
          clr_pend   = 1'b1;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pc_place   = place;
  assign bus.pc_select  = sel;
  assign bus.index      = index;
  assign bus.enable_buf = enable_buf;
  assign bus.flush      = flush;
  assign bus.save_pc    = save_pc;
  assign bus.int_ack    = int_ack;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Covers boot, sequential advance, stall, redirects, interrupt entry and
// reset abort, with hand-computed expected output values.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(.BOOT_CYCLES(2), .INT_SAVE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int place, input int sel,
                         input int en, input int fl, input int sv, input int ack);
    check_eq({tag, ".pc_place"},   int'(bus_if.pc_place),   place);
    check_eq({tag, ".pc_select"},  int'(bus_if.pc_select),  sel);
    check_eq({tag, ".enable_buf"}, int'(bus_if.enable_buf), en);
    check_eq({tag, ".flush"},      int'(bus_if.flush),      fl);
    check_eq({tag, ".save_pc"},    int'(bus_if.save_pc),    sv);
    check_eq({tag, ".int_ack"},    int'(bus_if.int_ack),    ack);
  endtask

  // Advance to just after the next rising edge, apply inputs for the whole
  // cycle, then leave a settle delay before the caller samples outputs.
  task automatic step(input logic st, input logic i32, input logic call,
                      input logic ret, input logic irq, input logic [2:0] idx);
    @(posedge clk);
    #1;
    bus_if.stall        = st;
    bus_if.inst_is_32   = i32;
    bus_if.call_taken   = call;
    bus_if.ret_taken    = ret;
    bus_if.int_req      = irq;
    bus_if.int_index_in = idx;
    #1;
  endtask

  initial begin
    reset               = 1'b0;
    bus_if.stall        = 1'b0;
    bus_if.inst_is_32   = 1'b0;
    bus_if.call_taken   = 1'b0;
    bus_if.ret_taken    = 1'b0;
    bus_if.int_req      = 1'b0;
    bus_if.int_index_in = 3'd0;
    #3;
    chk_out("reset", 8, 0, 0, 0, 0, 0);
    check_eq("reset.index", int'(bus_if.index), 0);

    // Boot: two reset-vector cycles, then sequential +2 fetch
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_out("boot1", 8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("boot2", 8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("run0", 0, 1, 1, 0, 0, 0);

    // Size-dependent advance and stalls
    step(0, 1, 0, 0, 0, 3'd0);
    chk_out("adv32a", 0, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("adv16", 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3'd0);
    chk_out("adv32b", 0, 2, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'd0);
    chk_out("stall1", 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3'd0);
    chk_out("stall2", 0, 0, 0, 0, 0, 0);

    // ret and call together: ret wins, one-cycle flush
    step(0, 0, 1, 1, 0, 3'd0);
    chk_out("retcall", 6, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("after_ret", 0, 1, 1, 0, 0, 0);

    // Interrupt entry, vector 3
    step(0, 0, 0, 0, 1, 3'd3);
    chk_out("int3_entry", 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int3_save0", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int3_save1", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int3_jump", 5, 0, 1, 0, 0, 1);
    check_eq("int3_jump.index", int'(bus_if.index), 3);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int3_back", 0, 1, 1, 0, 0, 0);

    // call with coincident interrupt: call first, then deferred entry
    step(0, 0, 1, 0, 1, 3'd5);
    chk_out("call_int", 7, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("pend_entry", 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 3'd0);
    chk_out("int5_save_stall", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int5_save0", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int5_save1", 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 3'd0);
    chk_out("int5_jump_stall", 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int5_jump", 5, 0, 1, 0, 0, 1);
    check_eq("int5_jump.index", int'(bus_if.index), 5);
    step(0, 1, 0, 0, 0, 3'd0);
    chk_out("int5_back", 0, 2, 1, 0, 0, 0);

    // Reset in the second save cycle aborts to BOOT without an ack
    step(0, 0, 0, 0, 1, 3'd2);
    chk_out("int2_entry", 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int2_save0", 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("int2_save1", 0, 0, 0, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk_out("abort", 8, 0, 0, 0, 0, 0);
    check_eq("abort.index", int'(bus_if.index), 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("abort_hold", 8, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_out("reboot1", 8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("reboot2", 8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk_out("rerun", 0, 1, 1, 0, 0, 0);
    check_eq("rerun.index", int'(bus_if.index), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
